// File: rtl/mxu_host.sv
// Host-side initiator: streams operands into the MXU, starts it, polls status, reads results back.
// Latency: 1 + N_OP + 1 + >=2 poll + 3 per result + 1 clear cycles when input and output never stall.
// Backpressure: in_ready only in LOAD; results are held stable in OUT_WAIT until out_ready.
module mxu_host #(
  parameter int          SIZE         = 16,
  parameter int          POLL_TIMEOUT = 4096,
  parameter logic [31:0] STATUS_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [31:0] awaddr,
  output logic [8:0]  wdata,
  output logic        wvalid,
  output logic [31:0] araddr,
  input  logic [31:0] rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int N_OP  = 2 * SIZE * SIZE;
  localparam int N_RES = SIZE * SIZE;
  localparam int OPW   = $clog2(N_OP + 1);
  localparam int IDXW  = (N_RES > 1) ? $clog2(N_RES) : 1;
  localparam int PCW   = $clog2(POLL_TIMEOUT + 1);

  localparam logic [OPW-1:0]  OP_LAST   = OPW'(N_OP - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N_RES - 1);
  localparam logic [PCW-1:0]  POLL_LAST = PCW'(POLL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_POLL, S_RD_ADDR, S_RD_DATA, S_OUT_WAIT, S_CLEAR
  } state_t;

  state_t          state, state_nxt;
  logic [OPW-1:0]  op_cnt, op_cnt_nxt;
  logic [IDXW-1:0] idx, idx_nxt;
  logic [PCW-1:0]  poll_cnt, poll_cnt_nxt;
  logic            out_valid_nxt;
  logic [31:0]     out_data_nxt;

  // State, counters and the registered result stage; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_cnt    <= '0;
      idx       <= '0;
      poll_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      op_cnt    <= op_cnt_nxt;
      idx       <= idx_nxt;
      poll_cnt  <= poll_cnt_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  // Next-state and bus strobes; writes in LOAD follow in_valid combinationally so no idle cycle writes.
  always_comb begin
    state_nxt     = state;
    op_cnt_nxt    = op_cnt;
    idx_nxt       = idx;
    poll_cnt_nxt  = poll_cnt;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    in_ready      = 1'b0;
    wvalid        = 1'b0;
    awaddr        = '0;
    wdata         = '0;
    araddr        = '0;
    done          = 1'b0;
    error         = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_nxt  = S_LOAD;
          op_cnt_nxt = '0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wvalid     = 1'b1;
          awaddr     = 32'(op_cnt) + 32'd1;
          wdata      = {1'b0, in_data};
          op_cnt_nxt = op_cnt + 1'b1;
          if (op_cnt == OP_LAST) state_nxt = S_START;
        end
      end
      S_START: begin
        wvalid       = 1'b1;
        wdata        = 9'h001;
        state_nxt    = S_POLL;
        poll_cnt_nxt = '0;
      end
      S_POLL: begin
        araddr       = STATUS_ADDR;
        poll_cnt_nxt = poll_cnt + 1'b1;
        // rdata answers the previous cycle's read, so the first POLL cycle carries no status.
        if (poll_cnt != '0 && rdata[1]) begin
          state_nxt = S_RD_ADDR;
          idx_nxt   = '0;
        end else if (poll_cnt == POLL_LAST) begin
          error     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        araddr    = 32'(idx);
        state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        araddr        = 32'(idx);
        out_data_nxt  = rdata;
        out_valid_nxt = 1'b1;
        state_nxt     = S_OUT_WAIT;
      end
      S_OUT_WAIT: begin
        araddr = 32'(idx);
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          if (idx == IDX_LAST) begin
            state_nxt = S_CLEAR;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_RD_ADDR;
          end
        end
      end
      S_CLEAR: begin
        wvalid    = 1'b1;
        wdata     = 9'h000;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mxu_host.sv
module tb_mxu_host;

  localparam int          SIZE  = 2;
  localparam int          N_OP  = 8;
  localparam int          N_RES = 4;
  localparam int          PT    = 16;
  localparam logic [31:0] SA    = 32'h8000_0000;

  logic        clk;
  logic        reset;
  logic        go;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [31:0] awaddr;
  logic [8:0]  wdata;
  logic        wvalid;
  logic [31:0] araddr;
  logic [31:0] rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic        error;

  mxu_host #(.SIZE(SIZE), .POLL_TIMEOUT(PT), .STATUS_ADDR(SA)) dut (
    .clk(clk), .reset(reset), .go(go),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .awaddr(awaddr), .wdata(wdata), .wvalid(wvalid),
    .araddr(araddr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wa_q[$];
  logic [8:0]  wd_q[$];
  logic [31:0] out_q[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          rd_hits  = 0;
  int          pcnt     = 0;
  bit          never_done = 1'b0;

  initial rdata = '0;

  // Bus monitor plus MXU slave model: status done after 10 polls, result[i] = 0x10 + i.
  always @(posedge clk) begin
    if (wvalid) begin
      wa_q.push_back(awaddr);
      wd_q.push_back(wdata);
    end
    if (out_valid && out_ready) out_q.push_back(out_data);
    if (done)  done_cnt <= done_cnt + 1;
    if (error) err_cnt  <= err_cnt + 1;
    if (araddr != 32'd0 && araddr != SA) rd_hits <= rd_hits + 1;
    if (araddr == SA)
      rdata <= (!never_done && pcnt >= 9) ? 32'h2 : 32'h0;
    else if (araddr < 32'(N_RES))
      rdata <= 32'h10 + araddr;
    else
      rdata <= 32'hDEAD_BEEF;
    if (wvalid && awaddr == 32'd0 && wdata == 9'h001) pcnt <= 0;
    else if (araddr == SA) pcnt <= pcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    out_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
    rd_hits  = 0;
  endtask

  task automatic start_and_load(input logic [7:0] base, input bit gappy);
    @(negedge clk);
    go = 1'b1; in_valid = 1'b0; #1;
    check("go_cycle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < N_OP; i++) begin
      logic [7:0] b;
      b = base + 8'(i);
      if (gappy) begin
        in_valid = 1'b0; #1;
        check("gap_wvalid", 32'(wvalid), 32'd0);
        check("gap_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = b; #1;
      check("ld_wvalid", 32'(wvalid), 32'd1);
      check("ld_awaddr", awaddr, 32'(i + 1));
      check("ld_wdata", 32'(wdata), 32'(b));
      @(negedge clk);
    end
    in_valid = 1'b0; #1;
    check("start_wvalid", 32'(wvalid), 32'd1);
    check("start_awaddr", awaddr, 32'd0);
    check("start_wdata", 32'(wdata), 32'h001);
  endtask

  // Cycles counted from the START cycle until done or error; 0 when the bound expires.
  task automatic wait_end(output int k);
    k = 0;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk); #1;
      if (done || error) begin
        k = j;
        return;
      end
    end
  endtask

  task automatic check_writes(input logic [7:0] base, input bit with_clear);
    check("wr_count", 32'(wa_q.size()), with_clear ? 32'd10 : 32'd9);
    for (int i = 0; i < N_OP; i++) begin
      logic [7:0] b;
      b = base + 8'(i);
      check("wr_addr", wa_q[i], 32'(i + 1));
      check("wr_data", 32'(wd_q[i]), 32'(b));
    end
    check("wr_start_addr", wa_q[8], 32'd0);
    check("wr_start_data", 32'(wd_q[8]), 32'h001);
    if (with_clear) begin
      check("wr_clear_addr", wa_q[9], 32'd0);
      check("wr_clear_data", 32'(wd_q[9]), 32'h000);
    end
  endtask

  task automatic check_results();
    check("out_count", 32'(out_q.size()), 32'd4);
    for (int i = 0; i < N_RES; i++)
      check("out_data", out_q[i], 32'h10 + 32'(i));
    check("done_count", 32'(done_cnt), 32'd1);
    check("err_count", 32'(err_cnt), 32'd0);
  endtask

  task automatic after_end();
    @(negedge clk); #1;
    check("post_busy", 32'(busy), 32'd0);
    check("post_done", 32'(done), 32'd0);
    check("post_error", 32'(error), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    reset = 1'b1;

    // Operand bytes offered in IDLE are refused
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h55; #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_wvalid", 32'(wvalid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; #1;
    check("idle_stays", 32'(busy), 32'd0);

    // Job 1: back-to-back bytes 0x01..0x08, minimum-latency job
    clear_logs();
    start_and_load(8'h01, 1'b0);
    wait_end(k);
    check("j1_cycles", 32'(k), 32'd24);
    check("j1_done", 32'(done), 32'd1);
    check("j1_error", 32'(error), 32'd0);
    after_end();
    check_writes(8'h01, 1'b1);
    check_results();

    // Job 2: in_valid toggling every other cycle
    clear_logs();
    start_and_load(8'hA1, 1'b1);
    wait_end(k);
    check("j2_cycles", 32'(k), 32'd24);
    after_end();
    check_writes(8'hA1, 1'b1);
    check_results();

    // Job 3: out_ready held low for 5 cycles on result 1
    clear_logs();
    start_and_load(8'h31, 1'b0);
    for (int j = 0; j < 100; j++) begin
      @(negedge clk); #1;
      if (out_valid && out_data == 32'h11) begin
        out_ready = 1'b0;
        break;
      end
    end
    repeat (5) begin
      @(negedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, 32'h11);
      check("bp_araddr", araddr, 32'd1);
    end
    out_ready = 1'b1;
    wait_end(k);
    check("j3_done", 32'(done), 32'd1);
    after_end();
    check_writes(8'h31, 1'b1);
    check_results();

    // Job 4: status never reports done -> timeout on the 16th poll cycle
    clear_logs();
    never_done = 1'b1;
    start_and_load(8'h51, 1'b0);
    wait_end(k);
    check("to_cycles", 32'(k), 32'd16);
    check("to_error", 32'(error), 32'd1);
    check("to_done", 32'(done), 32'd0);
    after_end();
    check("to_err_count", 32'(err_cnt), 32'd1);
    check("to_done_count", 32'(done_cnt), 32'd0);
    check("to_no_results", 32'(out_q.size()), 32'd0);
    check("to_no_reads", 32'(rd_hits), 32'd0);
    check_writes(8'h51, 1'b0);
    never_done = 1'b0;

    // Job 5: reset while waiting in OUT_WAIT, then a fresh full job
    clear_logs();
    out_ready = 1'b0;
    start_and_load(8'h61, 1'b0);
    for (int j = 0; j < 100; j++) begin
      @(negedge clk); #1;
      if (out_valid) break;
    end
    check("mr_out_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    @(negedge clk); #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_out_valid_clr", 32'(out_valid), 32'd0);
    check("mr_out_data", out_data, 32'd0);
    check("mr_araddr", araddr, 32'd0);
    check("mr_wvalid", 32'(wvalid), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    check("mr_no_clear", 32'(wa_q.size()), 32'd9);
    check("mr_no_done", 32'(done_cnt), 32'd0);

    clear_logs();
    out_ready = 1'b1;
    start_and_load(8'h71, 1'b0);
    wait_end(k);
    check("j5_cycles", 32'(k), 32'd24);
    after_end();
    check_writes(8'h71, 1'b1);
    check_results();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
